// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter in front of a single-ported data memory (DM).
// m0 is the CPU port and m1 is the DMA/loader port. When the two ports tie,
// the grant alternates between them. m1 can assert m1_lock to hold the
// memory for a burst of up to MAX_BURST beats before m0 gets a turn.
//
// A request seen in IDLE is granted at the next edge. In an OWNx state the
// beat happens combinationally: mx_ack goes high, the DM bus carries the mx
// fields, and mx_rdata returns dm_rdata.
//
// Ports:
//   CLK, reset                          clock, synchronous active-high reset
//   m0_req/we/size/addr/wdata           CPU request fields
//   m0_ack, m0_rdata                    CPU beat completion and read data
//   m1_req/we/size/addr/wdata, m1_lock  DMA request fields and burst lock
//   m1_ack, m1_rdata                    DMA beat completion and read data
//   dm_we, dm_size, dm_addr, dm_wdata   DM write enable, size, address, data
//   dm_rdata                            DM combinational read data
module dm_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        dm_we,
  output logic [2:0]  dm_size,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  // burst_cnt counts the locked beats already taken. The beat that happens
  // while burst_cnt equals BURST_LAST is the last beat of the burst.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        beat0, beat1;

  // Beats are gated by reset so no DM write can occur while reset is high.
  assign beat0 = !reset && (state_q == OWN0) && m0_req;
  assign beat1 = !reset && (state_q == OWN1) && m1_req;

  always_comb begin
    m0_ack   = beat0;
    m1_ack   = beat1;
    m0_rdata = beat0 ? dm_rdata : 32'd0;
    m1_rdata = beat1 ? dm_rdata : 32'd0;
    dm_we    = 1'b0;
    dm_size  = 3'd0;
    dm_addr  = 32'd0;
    dm_wdata = 32'd0;
    if (beat0) begin
      dm_we    = m0_we;
      dm_size  = m0_size;
      dm_addr  = m0_addr;
      dm_wdata = m0_wdata;
    end else if (beat1) begin
      dm_we    = m1_we;
      dm_size  = m1_size;
      dm_addr  = m1_addr;
      dm_wdata = m1_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      IDLE: begin
        // On a tie the grant goes to the port that was not served last.
        if (m0_req && (!m1_req || last_owner_q)) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d     = OWN1;
          burst_cnt_d = 4'd0;
        end
      end
      OWN0: begin
        // A withdrawn m0 falls through the same priority as a completed beat.
        if (m0_req) last_owner_d = 1'b0;
        if (m1_req) begin
          state_d     = OWN1;
          burst_cnt_d = 4'd0;
        end else if (m0_req) begin
          state_d = OWN0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (m1_req) begin
          last_owner_d = 1'b1;
          if (m1_lock && (burst_cnt_q < BURST_LAST)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end else if (m0_req) begin
            state_d = OWN0;
          end else begin
            // m1 keeps the memory, but the burst count starts over.
            burst_cnt_d = 4'd0;
          end
        end else begin
          state_d = m0_req ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter. A small word-addressed memory model sits on
// the DM side. Inputs change 1 time unit after the rising edge, and outputs
// are sampled on the falling edge.
module tb_dm_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [2:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_we;
  logic [2:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  logic [31:0] mem [16];
  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  dm_arbiter #(.MAX_BURST(4)) dut (
    .CLK(CLK), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  // DM model: combinational read, write committed at the rising edge
  assign dm_rdata = mem[dm_addr[5:2]];
  always @(posedge CLK) if (dm_we) mem[dm_addr[5:2]] <= dm_wdata;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Wait for the sampling point, then check both acks and that they never coincide.
  task automatic look(input string tag, input logic e0, input logic e1);
    @(negedge CLK);
    chk({tag, ".m0_ack"}, {31'd0, m0_ack}, {31'd0, e0});
    chk({tag, ".m1_ack"}, {31'd0, m1_ack}, {31'd0, e1});
    chk({tag, ".both"}, {31'd0, m0_ack & m1_ack}, 32'd0);
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_size = 3'd2; m0_addr = 32'h30; m0_wdata = 32'h5555_5555;
    m1_req = 1'b1; m1_we = 1'b1; m1_size = 3'd2; m1_addr = 32'h34; m1_wdata = 32'h6666_6666;
    m1_lock = 1'b0;
    nxt(); nxt();
    // Reset forces acks and dm_we low even with both ports requesting writes.
    look("rst", 1'b0, 1'b0);
    chk("rst.dm_we", {31'd0, dm_we}, 32'd0);
    nxt();

    // Single m0 write, then read back.
    reset = 1'b0; m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_size = 3'b010; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
    look("wr.c1", 1'b0, 1'b0);
    chk("wr.c1.dm_we", {31'd0, dm_we}, 32'd0);
    nxt();
    look("wr.c2", 1'b1, 1'b0);
    chk("wr.c2.dm_we", {31'd0, dm_we}, 32'd1);
    chk("wr.c2.dm_addr", dm_addr, 32'h10);
    chk("wr.c2.dm_wdata", dm_wdata, 32'hDEAD_BEEF);
    chk("wr.c2.dm_size", {29'd0, dm_size}, 32'd2);
    nxt();
    m0_req = 1'b0;
    look("wr.c3", 1'b0, 1'b0);
    chk("wr.c3.dm_addr", dm_addr, 32'd0);
    chk("wr.mem", mem[4], 32'hDEAD_BEEF);
    chk("rst.mem12", mem[12], 32'hA000_000C);
    nxt();
    m0_req = 1'b1; m0_we = 1'b0;
    look("rd.c1", 1'b0, 1'b0);
    nxt();
    look("rd.c2", 1'b1, 1'b0);
    chk("rd.c2.m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd.c2.dm_we", {31'd0, dm_we}, 32'd0);
    nxt();
    m0_req = 1'b0;
    look("rd.c3", 1'b0, 1'b0);
    nxt();

    // Both ports request from reset release, so the acks alternate starting with m0.
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h14;
    look("rr.c1", 1'b0, 1'b0);
    nxt();
    for (int k = 0; k < 4; k++) begin
      look($sformatf("rr.b%0d", k), (k % 2) == 0, (k % 2) == 1);
      if (k % 2 == 1) begin
        chk($sformatf("rr.b%0d.m1_rdata", k), m1_rdata, 32'hA000_0005);
        chk($sformatf("rr.b%0d.m0_rdata", k), m0_rdata, 32'd0);
      end
      nxt();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    look("rr.end", 1'b0, 1'b0);
    nxt();

    // Locked m1 burst with m0 waiting: four m1 beats, then m0, then m1 again.
    m1_req = 1'b1; m1_lock = 1'b1;
    look("bu.c1", 1'b0, 1'b0);
    nxt();
    m0_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      look($sformatf("bu.m1_%0d", k), 1'b0, 1'b1);
      nxt();
    end
    look("bu.m0", 1'b1, 1'b0);
    chk("bu.m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    nxt();
    look("bu.m1_resume", 1'b0, 1'b1);
    nxt();
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    look("bu.end", 1'b0, 1'b0);
    chk("bu.end.dm_we", {31'd0, dm_we}, 32'd0);
    nxt();

    // m1 is granted but withdraws its request; m0 is granted next.
    m1_req = 1'b1;
    look("wd.c1", 1'b0, 1'b0);
    nxt();
    m1_req = 1'b0; m0_req = 1'b1;
    look("wd.c2", 1'b0, 1'b0);
    chk("wd.c2.dm_we", {31'd0, dm_we}, 32'd0);
    nxt();
    look("wd.c3", 1'b1, 1'b0);
    nxt();
    m0_req = 1'b0;
    look("wd.c4", 1'b0, 1'b0);
    nxt();

    // Reset during an m1 write burst blocks the second write.
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1111_1111;
    look("rb.c1", 1'b0, 1'b0);
    nxt();
    look("rb.c2", 1'b0, 1'b1);
    chk("rb.c2.dm_we", {31'd0, dm_we}, 32'd1);
    nxt();
    m1_addr = 32'h24; m1_wdata = 32'h2222_2222;
    reset = 1'b1;
    look("rb.c3", 1'b0, 1'b0);
    chk("rb.c3.dm_we", {31'd0, dm_we}, 32'd0);
    nxt();
    chk("rb.mem8", mem[8], 32'h1111_1111);
    chk("rb.mem9", mem[9], 32'hA000_0009);
    reset = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h10;
    look("rb.t1", 1'b0, 1'b0);
    nxt();
    look("rb.t2", 1'b1, 1'b0);
    nxt();
    look("rb.t3", 1'b0, 1'b1);
    chk("rb.t3.m1_rdata", m1_rdata, 32'hA000_0009);
    nxt();
    m0_req = 1'b0; m1_req = 1'b0;
    look("rb.end", 1'b0, 1'b0);
    nxt();

    // m1 drops the lock after two beats, keeps single beats, and m0 cuts in.
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h14;
    look("ul.c1", 1'b0, 1'b0);
    nxt();
    look("ul.b0", 1'b0, 1'b1);
    nxt();
    look("ul.b1", 1'b0, 1'b1);
    nxt();
    m1_lock = 1'b0;
    look("ul.b2", 1'b0, 1'b1);
    nxt();
    m0_req = 1'b1;
    look("ul.b3", 1'b0, 1'b1);
    nxt();
    look("ul.m0", 1'b1, 1'b0);
    nxt();
    m0_req = 1'b0; m1_req = 1'b0;
    nxt(); nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
